// File: rtl/ucsbece154b_branch_gshare.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB and a 2-bit-counter PHT indexed in gshare or bimodal mode.
// Includes a PHT init/flush sweep FSM and saturating prediction statistics counters.
module ucsbece154b_branch_gshare #(
    parameter int GHR_W     = 5,
    parameter int BTB_IDX_W = 5,
    parameter int PRED_MODE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      pc_i,
    output logic             predtaken_o,
    output logic [31:0]      predtarget_o,
    output logic [GHR_W-1:0] phtidx_o,
    input  logic             upd_valid_i,
    input  logic             upd_branch_i,
    input  logic             upd_jump_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_pc_i,
    input  logic [31:0]      upd_target_i,
    input  logic [GHR_W-1:0] upd_phtidx_i,
    input  logic             upd_mispredict_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      mispred_cnt_o
);

    localparam int PHT_N = 1 << GHR_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               r_state;
    logic [GHR_W-1:0]     r_ptr;
    logic [GHR_W-1:0]     r_ghr;
    logic [BTB_N-1:0]     r_btb_valid;
    logic [TAG_W-1:0]     r_btb_tag    [BTB_N];
    logic [31:0]          r_btb_target [BTB_N];
    logic                 r_btb_jump   [BTB_N];
    logic [1:0]           r_pht        [PHT_N];
    logic [31:0]          r_branch_cnt;
    logic [31:0]          r_mispred_cnt;

    logic                 w_run;
    logic [BTB_IDX_W-1:0] w_fetch_idx;
    logic [TAG_W-1:0]     w_fetch_tag;
    logic                 w_hit;
    logic [GHR_W-1:0]     w_pht_idx;
    logic [BTB_IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0]     w_upd_tag;
    logic                 w_upd_en;
    logic                 w_upd_br;
    logic                 w_upd_jmp;
    logic                 w_btb_wr;
    logic [1:0]           w_pht_old;
    logic [1:0]           w_pht_new;
    logic                 w_unused;

    assign w_run       = (r_state == ST_RUN);
    assign w_fetch_idx = pc_i[BTB_IDX_W+1:2];
    assign w_fetch_tag = pc_i[31:BTB_IDX_W+2];
    assign w_upd_idx   = upd_pc_i[BTB_IDX_W+1:2];
    assign w_upd_tag   = upd_pc_i[31:BTB_IDX_W+2];
    assign w_unused    = ^{pc_i[1:0], upd_pc_i[1:0]};

    generate
        if (PRED_MODE != 0) begin : g_gshare
            assign w_pht_idx = pc_i[GHR_W+1:2] ^ r_ghr;
        end else begin : g_bimodal
            assign w_pht_idx = pc_i[GHR_W+1:2];
        end
    endgenerate

    // Flush takes priority over training; a branch with jump also set trains as a branch.
    assign w_upd_en  = w_run && upd_valid_i && !flush_i;
    assign w_upd_br  = w_upd_en && upd_branch_i;
    assign w_upd_jmp = w_upd_en && upd_jump_i && !upd_branch_i;
    assign w_btb_wr  = w_upd_jmp || (w_upd_br && upd_taken_i);

    assign w_hit        = r_btb_valid[w_fetch_idx] && (r_btb_tag[w_fetch_idx] == w_fetch_tag);
    assign predtaken_o  = w_run && w_hit && (r_btb_jump[w_fetch_idx] || r_pht[w_pht_idx][1]);
    assign predtarget_o = (w_run && w_hit) ? r_btb_target[w_fetch_idx] : '0;
    assign phtidx_o     = w_pht_idx;

    assign ready_o       = w_run;
    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

    assign w_pht_old = r_pht[upd_phtidx_i];

    // NOTE: default assignment first so every path drives w_pht_new and no latch is inferred.
    always_comb begin
        w_pht_new = w_pht_old;
        if (upd_taken_i && (w_pht_old != 2'b11)) begin
            w_pht_new = w_pht_old + 2'b01;
        end else if (!upd_taken_i && (w_pht_old != 2'b00)) begin
            w_pht_new = w_pht_old - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_INIT;
            r_ptr         <= '0;
            r_ghr         <= '0;
            r_btb_valid   <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_run && upd_valid_i && upd_mispredict_i && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
            if (w_run && upd_valid_i && upd_branch_i && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (r_state == ST_INIT) begin
                if (flush_i) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                    if (&r_ptr) begin
                        r_state <= ST_RUN;
                    end
                end
            end else begin
                if (flush_i) begin
                    r_state     <= ST_INIT;
                    r_ptr       <= '0;
                    r_ghr       <= '0;
                    r_btb_valid <= '0;
                end else begin
                    if (w_upd_br) begin
                        r_ghr <= {r_ghr[GHR_W-2:0], upd_taken_i};
                    end
                    if (w_btb_wr) begin
                        r_btb_valid[w_upd_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: table storage has no reset; the valid bits and the INIT sweep make its contents safe to use.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_pht[r_ptr] <= 2'b01;
        end else if (w_upd_br) begin
            r_pht[upd_phtidx_i] <= w_pht_new;
        end
        if (w_btb_wr) begin
            r_btb_tag[w_upd_idx]    <= w_upd_tag;
            r_btb_target[w_upd_idx] <= upd_target_i;
            r_btb_jump[w_upd_idx]   <= w_upd_jmp;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_branch_gshare.sv
// Self-checking bench: a reference model predicts each cycle's outputs into a scoreboard queue,
// popped and compared at the falling edge; directed sequences exercise training, saturation, flush and reset.
module tb_ucsbece154b_branch_gshare;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] pc_i;
    logic        upd_valid_i, upd_branch_i, upd_jump_i, upd_taken_i, upd_mispredict_i, flush_i;
    logic [31:0] upd_pc_i, upd_target_i;
    logic [4:0]  upd_phtidx_i;

    logic        predtaken_g, predtaken_b, ready_g, ready_b;
    logic [31:0] predtarget_g, predtarget_b, bcnt_g, bcnt_b, mcnt_g, mcnt_b;
    logic [4:0]  phtidx_g, phtidx_b;

    always #5 clk = ~clk;

    ucsbece154b_branch_gshare #(.GHR_W(5), .BTB_IDX_W(5), .PRED_MODE(1)) dut_g (
        .clk(clk), .reset_n(reset_n), .pc_i(pc_i),
        .predtaken_o(predtaken_g), .predtarget_o(predtarget_g), .phtidx_o(phtidx_g),
        .upd_valid_i(upd_valid_i), .upd_branch_i(upd_branch_i), .upd_jump_i(upd_jump_i),
        .upd_taken_i(upd_taken_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
        .upd_phtidx_i(upd_phtidx_i), .upd_mispredict_i(upd_mispredict_i), .flush_i(flush_i),
        .ready_o(ready_g), .branch_cnt_o(bcnt_g), .mispred_cnt_o(mcnt_g)
    );

    ucsbece154b_branch_gshare #(.GHR_W(5), .BTB_IDX_W(5), .PRED_MODE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .pc_i(pc_i),
        .predtaken_o(predtaken_b), .predtarget_o(predtarget_b), .phtidx_o(phtidx_b),
        .upd_valid_i(upd_valid_i), .upd_branch_i(upd_branch_i), .upd_jump_i(upd_jump_i),
        .upd_taken_i(upd_taken_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
        .upd_phtidx_i(upd_phtidx_i), .upd_mispredict_i(upd_mispredict_i), .flush_i(flush_i),
        .ready_o(ready_b), .branch_cnt_o(bcnt_b), .mispred_cnt_o(mcnt_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_run;
    logic [4:0]  m_ptr, m_ghr;
    logic [1:0]  m_pht   [32];
    bit          m_valid [32];
    logic [24:0] m_tag   [32];
    logic [31:0] m_tgt   [32];
    bit          m_jmp   [32];
    logic [31:0] m_bcnt, m_mcnt;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [4:0]  idx;
        logic        ready;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t sb_q[$];

    task automatic m_reset();
        m_run = 1'b0; m_ptr = '0; m_ghr = '0; m_bcnt = '0; m_mcnt = '0;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    endtask

    function automatic exp_t m_predict(input logic [31:0] pc);
        exp_t       e;
        logic [4:0] bi;
        logic [4:0] pi;
        bit         hit;
        bi  = pc[6:2];
        pi  = pc[6:2] ^ m_ghr;
        hit = m_valid[bi] && (m_tag[bi] == pc[31:7]);
        e.taken  = m_run && hit && (m_jmp[bi] || m_pht[pi][1]);
        e.target = (m_run && hit) ? m_tgt[bi] : 32'h0;
        e.idx    = pi;
        e.ready  = m_run;
        e.bcnt   = m_bcnt;
        e.mcnt   = m_mcnt;
        return e;
    endfunction

    task automatic m_btb_write(input bit is_jump);
        logic [4:0] bi;
        bi = upd_pc_i[6:2];
        m_valid[bi] = 1'b1;
        m_tag[bi]   = upd_pc_i[31:7];
        m_tgt[bi]   = upd_target_i;
        m_jmp[bi]   = is_jump;
    endtask

    task automatic m_update();
        logic [1:0] p;
        if (!m_run) begin
            m_pht[m_ptr] = 2'b01;
            if (flush_i) m_ptr = '0;
            else begin
                if (m_ptr == 5'd31) m_run = 1'b1;
                m_ptr = m_ptr + 5'd1;
            end
        end else begin
            if (upd_valid_i && upd_mispredict_i && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
            if (upd_valid_i && upd_branch_i && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
            if (flush_i) begin
                m_run = 1'b0; m_ptr = '0; m_ghr = '0;
                for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            end else if (upd_valid_i) begin
                if (upd_branch_i) begin
                    p = m_pht[upd_phtidx_i];
                    if (upd_taken_i && p != 2'd3) p = p + 2'd1;
                    else if (!upd_taken_i && p != 2'd0) p = p - 2'd1;
                    m_pht[upd_phtidx_i] = p;
                    m_ghr = {m_ghr[3:0], upd_taken_i};
                    if (upd_taken_i) m_btb_write(1'b0);
                end else if (upd_jump_i) begin
                    m_btb_write(1'b1);
                end
            end
        end
    endtask

    // One clock: expectation queued with the stimulus, compared at the falling edge, model stepped at the rising edge.
    task automatic cycle();
        exp_t e;
        sb_q.push_back(m_predict(pc_i));
        @(negedge clk);
        e = sb_q.pop_front();
        check("predtaken", predtaken_g, e.taken);
        check("predtarget", predtarget_g, e.target);
        check("phtidx", phtidx_g, e.idx);
        check("ready", ready_g, e.ready);
        check("branch_cnt", bcnt_g, e.bcnt);
        check("mispred_cnt", mcnt_g, e.mcnt);
        check("bim_phtidx", phtidx_b, pc_i[6:2]);
        check("bim_ready", ready_b, e.ready);
        @(posedge clk);
        if (reset_n) m_update();
        #1;
    endtask

    task automatic upd(input logic br, input logic jmp, input logic tk, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [4:0] idx, input logic mis);
        upd_valid_i = 1'b1; upd_branch_i = br; upd_jump_i = jmp; upd_taken_i = tk;
        upd_pc_i = pc; upd_target_i = tgt; upd_phtidx_i = idx; upd_mispredict_i = mis;
    endtask

    task automatic clr_upd();
        upd_valid_i = 1'b0; upd_branch_i = 1'b0; upd_jump_i = 1'b0; upd_taken_i = 1'b0;
        upd_pc_i = '0; upd_target_i = '0; upd_phtidx_i = '0; upd_mispredict_i = 1'b0;
    endtask

    // Bounded wait for ready_o; the sweep must take exactly 32 cycles.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_g && n < 100) begin
            cycle();
            n++;
        end
        check(tag, n, 32);
    endtask

    logic [4:0]  gk, ti;
    logic [31:0] mcnt_before, bcnt_before;

    initial begin
        pc_i = 32'h40;
        flush_i = 1'b0;
        clr_upd();
        for (int i = 0; i < 32; i++) m_pht[i] = 2'b00;
        m_reset();
        reset_n = 1'b0;
        repeat (3) cycle();

        // Reset release and PHT init sweep
        reset_n = 1'b1;
        wait_ready("init_latency");
        for (int i = 0; i < 32; i++) check("pht_init", dut_g.r_pht[i], 32'd1);

        // Branch at 0x40 taken twice to 0x10, trained on the index the third fetch will use
        pc_i = 32'h40;
        gk = {m_ghr[2:0], 2'b11};
        ti = 5'h10 ^ gk;
        repeat (2) begin
            upd(1'b1, 1'b0, 1'b1, 32'h40, 32'h10, ti, 1'b0);
            cycle();
        end
        clr_upd();
        cycle();
        check("br_taken", predtaken_g, 1);
        check("br_target", predtarget_g, 32'h10);
        check("br_cnt", bcnt_g, 2);

        // jal at 0x80 to 0x200, then an aliasing fetch with a different tag
        upd(1'b0, 1'b1, 1'b0, 32'h80, 32'h200, 5'd0, 1'b0);
        cycle();
        clr_upd();
        pc_i = 32'h80;
        #1;
        check("jal_taken", predtaken_g, 1);
        check("jal_target", predtarget_g, 32'h200);
        cycle();
        pc_i = 32'h100;
        #1;
        check("alias_taken", predtaken_g, 0);
        check("alias_target", predtarget_g, 0);
        cycle();

        // Branch and jump both set, not taken: must train as a branch and leave the BTB alone
        bcnt_before = bcnt_g;
        upd(1'b1, 1'b1, 1'b0, 32'hC4, 32'h900, 5'd4, 1'b0);
        cycle();
        clr_upd();
        pc_i = 32'hC4;
        #1;
        check("brjmp_taken", predtaken_g, 0);
        check("brjmp_cnt", bcnt_g - bcnt_before, 1);
        cycle();

        // PHT saturation at both ends on entry 9
        pc_i = 32'h1F8;
        repeat (6) begin
            upd(1'b1, 1'b0, 1'b1, 32'h1F8, 32'h20, 5'd9, 1'b0);
            cycle();
        end
        check("pht_sat_hi", dut_g.r_pht[9], 3);
        repeat (5) begin
            upd(1'b1, 1'b0, 1'b0, 32'h1F8, 32'h20, 5'd9, 1'b0);
            cycle();
        end
        check("pht_sat_lo", dut_g.r_pht[9], 0);
        upd(1'b1, 1'b0, 1'b1, 32'h1F8, 32'h20, 5'd9, 1'b0);
        cycle();
        check("pht_after_lo", dut_g.r_pht[9], 1);

        // Three mispredict pulses
        mcnt_before = mcnt_g;
        repeat (3) begin
            upd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
            cycle();
        end
        clr_upd();
        cycle();
        check("mispred_x3", mcnt_g - mcnt_before, 3);

        // Gshare vs bimodal index with GHR = 00101
        foreach (gk[i]) begin
            upd(1'b1, 1'b0, ((5'b00101 >> i) & 5'd1) != 0, 32'h1F8, 32'h20, 5'd2, 1'b0);
            cycle();
        end
        clr_upd();
        pc_i = 32'h0C;
        #1;
        check("gshare_idx", phtidx_g, 5'b00110);
        check("bimodal_idx", phtidx_b, 5'b00011);
        cycle();

        // Flush in RUN with an update pending
        bcnt_before = bcnt_g;
        mcnt_before = mcnt_g;
        upd(1'b1, 1'b0, 1'b1, 32'h2A0, 32'h500, 5'd0, 1'b1);
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        clr_upd();
        check("flush_ready", ready_g, 0);
        check("flush_bcnt", bcnt_g - bcnt_before, 1);
        check("flush_mcnt", mcnt_g - mcnt_before, 1);
        wait_ready("flush_latency");
        pc_i = 32'h40;  #1; check("flush_miss_40", predtaken_g, 0);
        pc_i = 32'h80;  #1; check("flush_miss_80", predtaken_g, 0);
        pc_i = 32'h2A0; #1; check("flush_miss_2a0", predtarget_g, 0);
        cycle();

        // Flush during INIT restarts the sweep
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        repeat (10) cycle();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        wait_ready("init_flush_latency");

        // Asynchronous reset mid-INIT
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        repeat (10) cycle();
        reset_n = 1'b0;
        #1;
        check("rst_ready", ready_g, 0);
        check("rst_bcnt", bcnt_g, 0);
        m_reset();
        cycle();
        reset_n = 1'b1;
        wait_ready("rst_latency");
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
